// File: rtl/series_result_collector.sv
// Output-end collector for the Q1.31 series pipeline: buffers final results in a
// first-word-fall-through FIFO and returns issue credits to the operand feeder.
module series_result_collector #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_sum,
  input  logic                       in_ovf,
  input  logic                       issue_req,
  output logic                       issue_ok,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_ovf,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_drop,
  output logic                       err_credit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_sum [DEPTH];
  logic [DEPTH-1:0] mem_ovf;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    credit;

  logic             pop;
  logic             push;
  logic             full;
  logic             credit_take;
  logic [WIDTH-1:0] stored_sum;

  assign full        = (count_q == FULL_COUNT);
  assign pop         = (count_q != '0) && out_ready;
  assign push        = in_valid && (!full || pop);
  assign credit_take = issue_req && issue_ok;

  // Overflowed results clamp toward the true sign, which is the inverse of the wrapped MSB.
  always_comb begin
    stored_sum = in_sum;
    if (SATURATE && in_ovf) begin
      if (in_sum[WIDTH-1])
        stored_sum = {1'b0, {(WIDTH-1){1'b1}}};
      else
        stored_sum = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_sum[i] <= '0;
      mem_ovf    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      credit     <= FULL_COUNT;
      err_drop   <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      if (push) begin
        mem_sum[wr_ptr] <= stored_sum;
        mem_ovf[wr_ptr] <= in_ovf;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;

      // A pop never lifts credit beyond DEPTH, even if results arrive unissued.
      if (credit_take && !pop)
        credit <= credit - 1'b1;
      else if (pop && !credit_take && credit != FULL_COUNT)
        credit <= credit + 1'b1;

      if (in_valid && full && !pop)
        err_drop <= 1'b1;
      if (issue_req && !issue_ok)
        err_credit <= 1'b1;
    end
  end

  assign issue_ok  = (credit != '0);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_sum[rd_ptr];
  assign out_ovf   = mem_ovf[rd_ptr];
  assign count     = count_q;

endmodule

// File: tb/tb_series_result_collector.sv
// Scoreboard bench for series_result_collector: one saturating and one wrapping
// instance share stimulus; expected results are queued on push and compared at the head.
module tb_series_result_collector;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_sum;
  logic             in_ovf;
  logic             issue_req;
  logic             out_ready;

  logic             issue_ok, out_valid, out_ovf, err_drop, err_credit;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  logic             w_issue_ok, w_out_valid, w_out_ovf, w_err_drop, w_err_credit;
  logic [WIDTH-1:0] w_out_data;
  logic [2:0]       w_count;

  typedef struct {
    logic [31:0] sat_data;
    logic [31:0] wrap_data;
    logic        ovf;
  } entry_t;

  entry_t sb[$];
  int     errors = 0;
  int     checks = 0;
  int     m_credit;
  logic   m_err_drop;
  logic   m_err_credit;
  int     pop_total = 0;

  always #5 clk = ~clk;

  series_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum), .in_ovf(in_ovf),
    .issue_req(issue_req), .issue_ok(issue_ok), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .count(count), .err_drop(err_drop),
    .err_credit(err_credit)
  );

  series_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum), .in_ovf(in_ovf),
    .issue_req(issue_req), .issue_ok(w_issue_ok), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_data(w_out_data), .out_ovf(w_out_ovf), .count(w_count), .err_drop(w_err_drop),
    .err_credit(w_err_credit)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("count", {29'd0, count}, sb.size());
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    checkOutput("issue_ok", {31'd0, issue_ok}, {31'd0, m_credit != 0});
    checkOutput("err_drop", {31'd0, err_drop}, {31'd0, m_err_drop});
    checkOutput("err_credit", {31'd0, err_credit}, {31'd0, m_err_credit});
    checkOutput("wrap_count", {29'd0, w_count}, sb.size());
    if (sb.size() != 0) begin
      checkOutput("head_sat", out_data, sb[0].sat_data);
      checkOutput("head_wrap", w_out_data, sb[0].wrap_data);
      checkOutput("head_ovf", {31'd0, out_ovf}, {31'd0, sb[0].ovf});
    end
  endtask

  // One clock of stimulus; the scoreboard and credit model advance alongside the DUT.
  task automatic applyStimulus(input logic iv, input logic [31:0] sum, input logic ovf,
                               input logic issue, input logic ready);
    entry_t e;
    bit pop, push, take;
    pop  = (sb.size() != 0) && ready;
    push = iv && ((sb.size() < DEPTH) || pop);
    take = issue && (m_credit != 0);
    if (iv && !push) m_err_drop = 1'b1;
    if (issue && m_credit == 0) m_err_credit = 1'b1;
    if (take && !pop) m_credit--;
    else if (pop && !take && m_credit < DEPTH) m_credit++;
    e.wrap_data = sum;
    e.ovf       = ovf;
    e.sat_data  = ovf ? (sum[31] ? 32'h7FFF_FFFF : 32'h8000_0000) : sum;

    in_valid  = iv;
    in_sum    = sum;
    in_ovf    = ovf;
    issue_req = issue;
    out_ready = ready;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(sb.pop_front());
      pop_total++;
    end
    if (push) sb.push_back(e);
    in_valid  = 1'b0;
    in_sum    = '0;
    in_ovf    = 1'b0;
    issue_req = 1'b0;
    out_ready = 1'b0;
    checkModel();
  endtask

  task automatic applyReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_ovf    = 1'b0;
    issue_req = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    m_credit     = DEPTH;
    m_err_drop   = 1'b0;
    m_err_credit = 1'b0;
    checkModel();
  endtask

  initial begin
    int   delivered;
    int   issued;
    int   pops_before;
    logic pending;
    logic take_now;

    applyReset();
    applyReset();
    checkOutput("reset_count", {29'd0, count}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_issue_ok", {31'd0, issue_ok}, 32'd1);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
    checkOutput("reset_err_drop", {31'd0, err_drop}, 32'd0);
    checkOutput("reset_err_credit", {31'd0, err_credit}, 32'd0);

    $display("[TB] single pass");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b1);
    checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_data", out_data, 32'h2000_0000);
    checkOutput("single_ovf", {31'd0, out_ovf}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("single_drained", {29'd0, count}, 32'd0);

    $display("[TB] credit exhaustion");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("exhaust_issue_ok", {31'd0, issue_ok}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("exhaust_err_credit", {31'd0, err_credit}, 32'd1);
    checkOutput("exhaust_still_zero", {31'd0, issue_ok}, 32'd0);
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("exhaust_full", {29'd0, count}, 32'd4);
    checkOutput("exhaust_head", out_data, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_issue_ok", {31'd0, issue_ok}, 32'd1);
    checkOutput("drain_head2", out_data, 32'h2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] saturation");
    applyStimulus(1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
    checkOutput("sat_pos_data", out_data, 32'h7FFF_FFFF);
    checkOutput("sat_pos_ovf", {31'd0, out_ovf}, 32'd1);
    checkOutput("wrap_pos_data", w_out_data, 32'h8000_0010);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h7FFF_FFF0, 1'b1, 1'b0, 1'b0);
    checkOutput("sat_neg_data", out_data, 32'h8000_0000);
    checkOutput("wrap_neg_data", w_out_data, 32'h7FFF_FFF0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] full boundary");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hA4, 1'b0, 1'b0, 1'b1);
    checkOutput("full_pushpop_count", {29'd0, count}, 32'd4);
    checkOutput("full_pushpop_err", {31'd0, err_drop}, 32'd0);
    applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("full_drop_err", {31'd0, err_drop}, 32'd1);
    checkOutput("full_drop_count", {29'd0, count}, 32'd4);
    checkOutput("full_drop_head", out_data, 32'hA1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] backpressure stream");
    delivered   = 0;
    issued      = 0;
    pending     = 1'b0;
    pops_before = pop_total;
    for (int cyc = 0; cyc < 100 && !(delivered == 10 && sb.size() == 0); cyc++) begin
      take_now = (issued < 10) && (m_credit != 0);
      applyStimulus(pending, 32'h10 + 32'(delivered), 1'b0, take_now, (cyc % 3) == 0);
      if (pending) delivered++;
      if (take_now) issued++;
      pending = take_now;
    end
    checkOutput("stream_delivered", 32'(delivered), 32'd10);
    checkOutput("stream_pops", 32'(pop_total - pops_before), 32'd10);
    checkOutput("stream_empty", {29'd0, count}, 32'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b1, 1'b0);
    checkOutput("mid_count", {29'd0, count}, 32'd3);
    applyReset();
    checkOutput("mid_reset_count", {29'd0, count}, 32'd0);
    checkOutput("mid_reset_issue_ok", {31'd0, issue_ok}, 32'd1);
    checkOutput("mid_reset_err_drop", {31'd0, err_drop}, 32'd0);
    checkOutput("mid_reset_err_credit", {31'd0, err_credit}, 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_reset_full_credit", {31'd0, issue_ok}, 32'd0);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_data", out_data, 32'h55);
    checkOutput("post_reset_count", {29'd0, count}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_empty", {31'd0, out_valid}, 32'd0);
    checkOutput("post_reset_credit", {31'd0, issue_ok}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
